// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC and reads instruction memory over a req/gnt/rvalid handshake,
// with at most one request outstanding. The fetched word is registered into
// the decode slot (InstrD/PCD/PCPlus4D/ValidD).
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   PCSrcE       redirect from execute (taken branch / jump)
//   PCTargetE    redirect target; bits [1:0] are ignored
//   StallD       decode cannot accept a new instruction
//   FlushD       invalidate the decode slot
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address (the PC)
//   imem_gnt     memory accepts the request
//   imem_rvalid  read data valid
//   imem_rdata   instruction word
//   InstrD       instruction to decode (NOP_INSTR when empty)
//   PCD          PC of InstrD
//   PCPlus4D     PCD + 4
//   ValidD       InstrD holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] skid;
    logic [31:0] skid_nxt;
    logic        kill;
    logic        kill_nxt;
    logic        load;
    logic [31:0] load_data;
    logic        slot_free;
    logic [31:0] target;

    // Redirect targets are forced word-aligned.
    assign target    = PCTargetE & 32'hFFFF_FFFC;
    assign slot_free = !ValidD || !StallD;
    // Request is suppressed while reset is held so nothing is issued mid-reset.
    assign imem_req  = rst && (state == REQ);
    assign imem_addr = pc;

    // Next-state, PC, kill and skid logic.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        skid_nxt  = skid;
        load      = 1'b0;
        load_data = skid;
        case (state)
            REQ: begin
                if (imem_gnt) begin
                    state_nxt = WAIT;
                    // A redirect in the grant cycle orphans the request just issued.
                    if (PCSrcE) begin
                        kill_nxt = 1'b1;
                    end else begin
                        kill_nxt = kill;
                    end
                end else begin
                    state_nxt = REQ;
                end
                if (PCSrcE) begin
                    pc_nxt = target;
                end else begin
                    pc_nxt = pc;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || PCSrcE) begin
                        // Stale or redirected response: drop it and refetch.
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else if (slot_free && !FlushD) begin
                        load      = 1'b1;
                        load_data = imem_rdata;
                        state_nxt = REQ;
                    end else begin
                        skid_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else begin
                    if (PCSrcE) begin
                        kill_nxt = 1'b1;
                    end else begin
                        kill_nxt = kill;
                    end
                end
                if (PCSrcE) begin
                    pc_nxt = target;
                end else if (load) begin
                    pc_nxt = pc + 32'd4;
                end else begin
                    pc_nxt = pc;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (slot_free && !FlushD) begin
                    load      = 1'b1;
                    load_data = skid;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

    // State registers and the decode-slot output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= REQ;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            skid     <= 32'd0;
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            skid  <= skid_nxt;
            if (FlushD) begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else if (StallD && ValidD) begin
                InstrD <= InstrD;
            end else if (load) begin
                InstrD   <= load_data;
                PCD      <= pc;
                PCPlus4D <= pc + 32'd4;
                ValidD   <= 1'b1;
            end else if (!StallD) begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else begin
                ValidD <= ValidD;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural memory with random
// grant/latency, and a program-order scoreboard that expects a contiguous
// PC stream restarting at each redirect target or reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        else if (a == 32'd4) return 32'h00A0_0113;
        else return (a * 32'h9E37_79B1) ^ 32'h1234_5673;
    endfunction

    // Reference state
    logic [31:0] exp_pc;
    int          delivered;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat_min;
    int          lat_max;
    int          gnt_pct;
    logic [31:0] acc_addr[$];

    // One clock: sample pre-edge context, cross the edge, score, then update memory.
    task automatic tick();
        logic        rst_e, st_e, fl_e, rd_e, rv_e, req_e, gnt_e;
        logic [31:0] tg_e, addr_e, p_instr, p_pcd, p_pc4;
        logic        p_valid;
        #1;
        rst_e = rst; st_e = StallD; fl_e = FlushD; rd_e = PCSrcE; tg_e = PCTargetE;
        rv_e = imem_rvalid; req_e = imem_req; gnt_e = imem_gnt; addr_e = imem_addr;
        p_valid = ValidD; p_instr = InstrD; p_pcd = PCD; p_pc4 = PCPlus4D;
        check_eq("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (!rst_e) check_eq("req_in_reset", {31'd0, imem_req}, 32'd0);
        if (imem_req) check_eq("one_outstanding", {31'd0, pend}, 32'd0);
        @(posedge clk);
        #1;
        if (!rst_e) begin
            check_eq("rst_valid", {31'd0, ValidD}, 32'd0);
            check_eq("rst_instr", InstrD, NOP);
            check_eq("rst_pcd", PCD, 32'd0);
            check_eq("rst_pc4", PCPlus4D, 32'd0);
            exp_pc = 32'd0;
        end else begin
            if (fl_e) begin
                check_eq("flush_valid", {31'd0, ValidD}, 32'd0);
                check_eq("flush_instr", InstrD, NOP);
            end else if (st_e && p_valid) begin
                check_eq("stall_valid", {31'd0, ValidD}, 32'd1);
                check_eq("stall_instr", InstrD, p_instr);
                check_eq("stall_pcd", PCD, p_pcd);
                check_eq("stall_pc4", PCPlus4D, p_pc4);
            end else if (ValidD) begin
                check_eq("deliver_pcd", PCD, exp_pc);
                check_eq("deliver_instr", InstrD, mem_word(exp_pc));
                check_eq("deliver_pc4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                check_eq("empty_instr", InstrD, NOP);
            end
            if (rd_e) exp_pc = tg_e & 32'hFFFF_FFFC;
        end
        // Memory model
        if (!rst_e) begin
            pend = 1'b0;
        end else begin
            if (rv_e) pend = 1'b0;
            if (req_e && gnt_e) begin
                pend      = 1'b1;
                pend_addr = addr_e;
                pend_cnt  = $urandom_range(lat_max, lat_min);
                acc_addr.push_back(addr_e);
            end
        end
        if (pend && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_cnt--;
        end
        imem_gnt = imem_req && ($urandom_range(99, 0) < gnt_pct);
    endtask

    task automatic redirect(input logic [31:0] t);
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = t;
        tick();
        PCSrcE = 1'b0; FlushD = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0; StallD = 1'b0; FlushD = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        pend = 1'b0; pend_addr = 32'd0; pend_cnt = 0; exp_pc = 32'd0; delivered = 0;
        lat_min = 0; lat_max = 0; gnt_pct = 100;

        // Reset release, zero-wait memory: addresses 0,4,8
        tick(); tick();
        rst = 1'b1;
        acc_addr.delete();
        for (int i = 0; i < 40 && acc_addr.size() < 3; i++) tick();
        check_eq("boot_req_count", {31'd0, acc_addr.size() >= 3}, 32'd1);
        if (acc_addr.size() >= 3) begin
            check_eq("boot_addr0", acc_addr[0], 32'd0);
            check_eq("boot_addr1", acc_addr[1], 32'd4);
            check_eq("boot_addr2", acc_addr[2], 32'd8);
        end
        check_eq("boot_delivered", {31'd0, delivered >= 2}, 32'd1);

        // Stall across a returning word
        for (int i = 0; i < 20 && !ValidD; i++) tick();
        d0 = delivered;
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        StallD = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("stall_progress", {31'd0, delivered >= d0 + 2}, 32'd1);

        // Redirect coinciding with rvalid
        for (int i = 0; i < 20 && !imem_rvalid; i++) tick();
        check_eq("rv_seen", {31'd0, imem_rvalid}, 32'd1);
        redirect(32'h0000_0100);
        check_eq("rv_redirect_addr", imem_addr, 32'h0000_0100);
        check_eq("rv_redirect_req", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 10; i++) tick();

        // Redirect while waiting on a slow response
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(pend && !imem_rvalid); i++) tick();
        check_eq("wait_seen", {31'd0, pend && !imem_rvalid}, 32'd1);
        redirect(32'h0000_0040);
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        check_eq("kill_req", {31'd0, imem_req}, 32'd1);
        check_eq("kill_addr", imem_addr, 32'h0000_0040);
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 10; i++) tick();

        // Flush with a valid slot
        for (int i = 0; i < 20 && !ValidD; i++) tick();
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        check_eq("flushd_valid", {31'd0, ValidD}, 32'd0);
        check_eq("flushd_instr", InstrD, NOP);

        // Unaligned target while request is not yet granted
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        imem_gnt = 1'b0;
        redirect(32'h0000_0103);
        check_eq("align_addr", imem_addr, 32'h0000_0100);
        check_eq("align_req", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 8; i++) tick();

        // PC wrap-around
        redirect(32'hFFFF_FFFC);
        acc_addr.delete();
        for (int i = 0; i < 30 && acc_addr.size() < 2; i++) tick();
        check_eq("wrap_count", {31'd0, acc_addr.size() >= 2}, 32'd1);
        if (acc_addr.size() >= 2) begin
            check_eq("wrap_addr0", acc_addr[0], 32'hFFFF_FFFC);
            check_eq("wrap_addr1", acc_addr[1], 32'd0);
        end
        for (int i = 0; i < 6; i++) tick();

        // Reset during WAIT
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(pend && !imem_rvalid); i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 10; i++) tick();

        // Randomized traffic
        lat_min = 0; lat_max = 3; gnt_pct = 60;
        d0 = delivered;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(99, 0);
            StallD = ($urandom_range(99, 0) < 30);
            rst    = !(r < 1);
            if (r >= 1 && r < 6) begin
                PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = $urandom;
            end else begin
                PCSrcE = 1'b0; FlushD = (r >= 6 && r < 11);
            end
            tick();
        end
        check_eq("random_progress", {31'd0, delivered >= d0 + 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
